st_logic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered bitwise-logic datapath (OR/AND/XOR/pass) between two Avalon-ST requesters. Each requester presents an operand pair plus opcode on its sink; the block grants one requester at a time, computes the result, and returns it on that requester's own source stream. It sits between two client masters and the shared logic unit in the exam integration design.

---
 rtl/st_logic_pkg.sv | 40 ++++
 rtl/st_logic_alu.sv | 23 ++
 rtl/st_logic_arbiter.sv | 110 +++++++++++
 tb/tb_st_logic_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_logic_pkg.sv
// Shared types and request-field layout for the two-requester bitwise-logic arbiter.
package st_logic_pkg;

  typedef enum logic [1:0] {
    OP_OR   = 2'd0,
    OP_AND  = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned N_DEFAULT = 32;

  // Request word layout: {op[1:0], A[N-1:0], B[N-1:0]}
  function automatic int unsigned req_width(input int unsigned n);
    return 2 * n + 2;
  endfunction

  function automatic int unsigned b_lsb(input int unsigned n);
    return 0 * n;
  endfunction

  function automatic int unsigned a_lsb(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned n);
    return 2 * n;
  endfunction

  localparam int unsigned REQ_W_DEFAULT  = req_width(N_DEFAULT);
  localparam int unsigned OP_LSB_DEFAULT = op_lsb(N_DEFAULT);
  localparam int unsigned A_LSB_DEFAULT  = a_lsb(N_DEFAULT);
  localparam int unsigned B_LSB_DEFAULT  = b_lsb(N_DEFAULT);

endpackage

// File: rtl/st_logic_alu.sv
// Combinational bitwise-logic unit; the arbiter registers its result.
module st_logic_alu
  import st_logic_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  op_e          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_PASS: result = a;
    endcase
  end

endmodule

// File: rtl/st_logic_arbiter.sv
// Round-robin arbiter sharing one registered logic unit between two Avalon-ST requesters.
module st_logic_arbiter
  import st_logic_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                clock_clk,
  input  logic                reset_reset_n,
  input  logic [2*N+1:0]      asi_req0_data,
  input  logic                asi_req0_valid,
  output logic                asi_req0_ready,
  input  logic [2*N+1:0]      asi_req1_data,
  input  logic                asi_req1_valid,
  output logic                asi_req1_ready,
  output logic [N-1:0]        aso_rsp0_data,
  output logic                aso_rsp0_valid,
  input  logic                aso_rsp0_ready,
  output logic [N-1:0]        aso_rsp1_data,
  output logic                aso_rsp1_valid,
  input  logic                aso_rsp1_ready,
  output logic                busy
);

  localparam int unsigned OP_LSB = op_lsb(N);
  localparam int unsigned A_LSB  = a_lsb(N);
  localparam int unsigned B_LSB  = b_lsb(N);

  state_e         state, state_nxt;
  logic           rr;
  logic           owner;
  logic           gnt_vld;
  logic           gnt_idx;
  logic [2*N+1:0] sel_req;
  logic [N-1:0]   alu_res;
  logic           accept;
  logic           release_rsp;

  // Grant depends only on sink valids and rr; response readies never feed it.
  always_comb begin
    gnt_vld = asi_req0_valid | asi_req1_valid;
    gnt_idx = 1'b0;
    if (asi_req0_valid && asi_req1_valid) gnt_idx = rr;
    else if (asi_req1_valid)              gnt_idx = 1'b1;
  end

  assign sel_req = gnt_idx ? asi_req1_data : asi_req0_data;

  st_logic_alu #(.N(N)) u_alu (
    .op     (op_e'(sel_req[OP_LSB +: 2])),
    .a      (sel_req[A_LSB +: N]),
    .b      (sel_req[B_LSB +: N]),
    .result (alu_res)
  );

  assign accept      = (state == IDLE) && gnt_vld;
  assign release_rsp = (state == HOLD) &&
                       (owner ? (aso_rsp1_valid && aso_rsp1_ready)
                              : (aso_rsp0_valid && aso_rsp0_ready));

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)      state_nxt = HOLD;
      HOLD: if (release_rsp) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    asi_req0_ready = 1'b0;
    asi_req1_ready = 1'b0;
    busy           = 1'b0;
    unique case (state)
      IDLE: begin
        asi_req0_ready = gnt_vld && !gnt_idx;
        asi_req1_ready = gnt_vld &&  gnt_idx;
      end
      HOLD: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rr             <= 1'b0;
      owner          <= 1'b0;
      aso_rsp0_data  <= '0;
      aso_rsp0_valid <= 1'b0;
      aso_rsp1_data  <= '0;
      aso_rsp1_valid <= 1'b0;
    end else if (accept) begin
      rr    <= ~gnt_idx;
      owner <= gnt_idx;
      if (gnt_idx) begin
        aso_rsp1_data  <= alu_res;
        aso_rsp1_valid <= 1'b1;
      end else begin
        aso_rsp0_data  <= alu_res;
        aso_rsp0_valid <= 1'b1;
      end
    end else if (release_rsp) begin
      if (owner) aso_rsp1_valid <= 1'b0;
      else       aso_rsp0_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_st_logic_arbiter.sv
// Self-checking bench for st_logic_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_st_logic_arbiter;

  localparam int unsigned N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2*N+1:0] d0 = '0, d1 = '0;
  logic           v0 = 1'b0, v1 = 1'b0;
  logic           rr0 = 1'b0, rr1 = 1'b0;
  logic           ready0, ready1;
  logic [N-1:0]   rsp0_data, rsp1_data;
  logic           rsp0_valid, rsp1_valid;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction model: who holds the unit, who is preferred next, and the result each requester sees.
  bit          m_busy;
  int          m_owner;
  int          m_pref;
  bit          m_rv [2];
  logic [31:0] m_rd [2];

  always #5 clk = ~clk;

  st_logic_arbiter #(.N(N)) dut (
    .clock_clk      (clk),
    .reset_reset_n  (rst_n),
    .asi_req0_data  (d0),
    .asi_req0_valid (v0),
    .asi_req0_ready (ready0),
    .asi_req1_data  (d1),
    .asi_req1_valid (v1),
    .asi_req1_ready (ready1),
    .aso_rsp0_data  (rsp0_data),
    .aso_rsp0_valid (rsp0_valid),
    .aso_rsp0_ready (rr0),
    .aso_rsp1_data  (rsp1_data),
    .aso_rsp1_valid (rsp1_valid),
    .aso_rsp1_ready (rr1),
    .busy           (busy)
  );

  function automatic logic [2*N+1:0] mk(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [1:0] o;
    o = op[1:0];
    return {o, a, b};
  endfunction

  function automatic logic [31:0] calc(input logic [2*N+1:0] d);
    logic [31:0] a, b;
    a = d[63:32];
    b = d[31:0];
    case (d[65:64])
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic int exp_grant();
    if (m_busy)        return -1;
    if (v0 && v1)      return m_pref;
    if (v0)            return 0;
    if (v1)            return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_pref = 0;
    m_rv[0] = 0; m_rv[1] = 0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // Advance one clock from a negedge; model follows the inputs seen at the edge.
  task automatic tick();
    int g;
    bit rdy;
    g   = exp_grant();
    rdy = (m_owner == 0) ? rr0 : rr1;
    @(posedge clk);
    if (g >= 0) begin
      m_rd[g]  = calc(g == 0 ? d0 : d1);
      m_rv[g]  = 1;
      m_owner  = g;
      m_pref   = 1 - g;
      m_busy   = 1;
    end else if (m_busy && rdy) begin
      m_rv[m_owner] = 0;
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] held;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({ready0, ready1, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b want=00000", {ready0, ready1, rsp0_valid, rsp1_valid, busy});
    end
    rst_n = 1'b1;
    model_reset();
    v0 = 1; d0 = mk(2, 32'h1234_5678, 32'hFFFF_0000); rr0 = 0;
    #1;
    tick();
    v0 = 0;
    tick();
    #1;
    held = rsp0_data;
    n_cmp++; if (busy !== 1'b1 || held !== 32'hEDCB_5678) begin
      n_bad++; $display("FAIL pre_reset_hold busy=%b data=%h want busy=1 data=edcb5678", busy, held);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({ready0, ready1, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      n_bad++; $display("FAIL reset_midhold_ctrl got=%b want=00000", {ready0, ready1, rsp0_valid, rsp1_valid, busy});
    end
    n_cmp++; if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_midhold_data got=%h/%h want=0/0", rsp0_data, rsp1_data);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 1; v1 = 1; d0 = mk(3, 32'hAAAA_AAAA, 32'h0); d1 = mk(3, 32'h5555_5555, 32'h0);
    #1;
    n_cmp++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_first_grant got=%b%b want=10", ready0, ready1);
    end
    rr0 = 1;
    tick();
    v0 = 0; v1 = 0;
    tick();
  endtask

  task automatic test_single();
    v0 = 1; v1 = 0; rr0 = 1; d0 = mk(0, 32'hF0F0_0000, 32'h0000_0F0F);
    #1;
    n_cmp++; if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL single_ready_t got=%b want=1", ready0);
    end
    tick();
    #1;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hF0F0_0F0F) begin
      n_bad++; $display("FAIL single_rsp got v=%b d=%h want v=1 d=f0f00f0f", rsp0_valid, rsp0_data);
    end
    n_cmp++; if (ready0 !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_hold got rdy=%b busy=%b want 0/1", ready0, busy);
    end
    tick();
    #1;
    n_cmp++; if (ready0 !== 1'b1 || rsp0_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_t2_accept got rdy=%b v=%b want 1/0", ready0, rsp0_valid);
    end
    tick();
    v0 = 0;
    tick();
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] want [4];
    want[0] = 32'hFF0F_FF0F; want[1] = 32'h0F00_0F00;
    want[2] = 32'hF00F_F00F; want[3] = 32'hFF00_FF00;
    v0 = 0; rr1 = 1;
    for (int op = 0; op < 4; op++) begin
      v1 = 1; d1 = mk(op, 32'hFF00_FF00, 32'h0F0F_0F0F);
      #1;
      n_cmp++; if (ready1 !== 1'b1) begin
        n_bad++; $display("FAIL sweep_ready op=%0d got=%b want=1", op, ready1);
      end
      tick();
      v1 = 0;
      #1;
      n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_data !== want[op]) begin
        n_bad++; $display("FAIL sweep_rsp op=%0d got v=%b d=%h want v=1 d=%h", op, rsp1_valid, rsp1_data, want[op]);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    int first;
    int want;
    first = m_pref;
    v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
    for (int i = 0; i < 6; i++) begin
      d0 = mk(int'($urandom_range(0, 3)), $urandom, $urandom);
      d1 = mk(int'($urandom_range(0, 3)), $urandom, $urandom);
      want = (first + i) % 2;
      #1;
      n_cmp++; if (ready0 !== (want == 0) || ready1 !== (want == 1)) begin
        n_bad++; $display("FAIL contention_grant i=%0d got=%b%b want_idx=%0d", i, ready0, ready1, want);
      end
      tick();
      #1;
      n_cmp++; if ((want == 0 ? rsp0_data : rsp1_data) !== m_rd[want] || ready0 !== 1'b0 || ready1 !== 1'b0) begin
        n_bad++; $display("FAIL contention_rsp i=%0d got d0=%h d1=%h rdy=%b%b want d=%h rdy=00", i, rsp0_data, rsp1_data, ready0, ready1, m_rd[want]);
      end
      tick();
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    v0 = 1; v1 = 0; rr0 = 0; rr1 = 1;
    d0 = mk(1, 32'hDEAD_BEEF, 32'h0FF0_FFFF);
    want = 32'h0EA0_BEEF;
    #1;
    tick();
    v1 = 1; d1 = mk(0, 32'h0000_0001, 32'h8000_0000);
    d0 = mk(3, 32'h1111_1111, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== want || ready0 !== 1'b0 || ready1 !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL backpressure_hold i=%0d got v=%b d=%h rdy=%b%b busy=%b want v=1 d=%h rdy=00 busy=1",
                          i, rsp0_valid, rsp0_data, ready0, ready1, busy, want);
      end
      tick();
    end
    rr0 = 1;
    tick();
    #1;
    n_cmp++; if (ready1 !== 1'b1 || ready0 !== 1'b0 || rsp0_valid !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_next_grant got rdy=%b%b v0=%b want rdy=01 v0=0", ready0, ready1, rsp0_valid);
    end
    tick();
    v0 = 0; v1 = 0;
    #1;
    n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h8000_0001) begin
      n_bad++; $display("FAIL backpressure_rsp1 got v=%b d=%h want v=1 d=80000001", rsp1_valid, rsp1_data);
    end
    tick();
  endtask

  task automatic test_withdrawn();
    v0 = 1; v1 = 0; rr0 = 0; d0 = mk(2, 32'hCAFE_0000, 32'h0000_CAFE);
    #1;
    tick();
    v0 = 0;
    v1 = 1; d1 = mk(3, 32'h7777_7777, 32'h0);
    #1;
    n_cmp++; if (ready1 !== 1'b0) begin
      n_bad++; $display("FAIL withdrawn_no_grant got=%b want=0", ready1);
    end
    tick();
    v1 = 0; rr0 = 1;
    tick();
    v0 = 1; v1 = 1;
    d0 = mk(0, 32'h0000_00F0, 32'h0000_000F);
    #1;
    n_cmp++; if (ready1 !== 1'b1 || ready0 !== 1'b0) begin
      n_bad++; $display("FAIL withdrawn_rr_kept got=%b%b want=01", ready0, ready1);
    end
    rr1 = 1;
    tick();
    v1 = 0;
    tick();
    #1;
    n_cmp++; if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL withdrawn_req0_ready got=%b want=1", ready0);
    end
    tick();
    v0 = 0;
    #1;
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_00FF) begin
      n_bad++; $display("FAIL withdrawn_req0_rsp got v=%b d=%h want v=1 d=000000ff", rsp0_valid, rsp0_data);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      v0  = 1'($urandom_range(0, 1));
      v1  = 1'($urandom_range(0, 1));
      rr0 = ($urandom_range(0, 9) < 7);
      rr1 = ($urandom_range(0, 9) < 7);
      d0  = mk(int'($urandom_range(0, 3)), $urandom, $urandom);
      d1  = mk(int'($urandom_range(0, 3)), $urandom, $urandom);
      #1;
      g = exp_grant();
      n_cmp++; if (ready0 !== (g == 0) || ready1 !== (g == 1) || busy !== m_busy) begin
        n_bad++; $display("FAIL random_ctrl i=%0d got rdy=%b%b busy=%b want grant=%0d busy=%b", i, ready0, ready1, busy, g, m_busy);
      end
      n_cmp++; if (rsp0_valid !== m_rv[0] || rsp1_valid !== m_rv[1] || rsp0_data !== m_rd[0] || rsp1_data !== m_rd[1]) begin
        n_bad++; $display("FAIL random_rsp i=%0d got v=%b%b d0=%h d1=%h want v=%b%b d0=%h d1=%h",
                          i, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, m_rv[0], m_rv[1], m_rd[0], m_rd[1]);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_opcode_sweep();
    test_contention();
    test_backpressure();
    test_withdrawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
